// File: rtl/uart_rx_if.sv
// Serial-receive bundle: line and baud tick in, received byte and status pulses out.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 baud_tick;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_done;
  logic                 frame_err;
  logic                 rx_busy;

  modport master (
    output baud_tick, rx,
    input  rx_data, rx_done, frame_err, rx_busy
  );

  modport slave (
    input  baud_tick, rx,
    output rx_data, rx_done, frame_err, rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: mid-bit sampling, one stop bit, break detection
// so a line held low after a framing error cannot start a new frame.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t               state, state_nxt;
  logic                 rx_meta, rx_s;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg, data_q;
  logic                 done_q, ferr_q, busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.baud_tick && !rx_s) state_nxt = S_START;
      S_START: if (bus.baud_tick && tick_cnt == HALF_LAST)
                 state_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (bus.baud_tick && tick_cnt == TICK_LAST && bit_cnt == BIT_LAST)
                 state_nxt = S_STOP;
      S_STOP:  if (bus.baud_tick && tick_cnt == TICK_LAST)
                 state_nxt = rx_s ? S_IDLE : S_BREAK;
      // Leaving BREAK needs no tick: any return of the line to idle ends it.
      S_BREAK: if (rx_s) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      if (bus.baud_tick) begin
        case (state)
          S_IDLE: begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end
          S_START: begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          S_DATA: begin
            if (tick_cnt == TICK_LAST) begin
              shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
              tick_cnt <= '0;
              bit_cnt  <= bit_cnt + BW'(1);
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          S_STOP: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              if (rx_s) begin
                data_q <= shreg;
                done_q <= 1'b1;
              end else begin
                ferr_q <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          default: tick_cnt <= '0;
        endcase
      end
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_done   = done_q;
  assign bus.frame_err = ferr_q;
  assign bus.rx_busy   = busy;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written
// sequences for glitch, back-to-back, break, mid-frame reset and tick-per-clk.
module tb_uart_rx;
  localparam int OS       = 8;
  localparam int TICK_DIV = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_if #(.DATA_BITS(8)) bus ();
  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   tick_high = 1'b0;
  int   tcnt = 0;

  int         done_cnt = 0, ferr_cnt = 0, both_cnt = 0, wide_cnt = 0;
  logic       prev_done = 1'b0, prev_ferr = 1'b0;
  logic [7:0] done_log[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_done;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bus.baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_high) begin
        bus.baud_tick = 1'b1;
      end else begin
        tcnt = (tcnt + 1 >= TICK_DIV) ? 0 : tcnt + 1;
        bus.baud_tick = (tcnt == 0);
      end
    end
  end

  always @(negedge clk) begin
    if (bus.rx_done) begin
      done_cnt++;
      done_log.push_back(bus.rx_data);
    end
    if (bus.frame_err) ferr_cnt++;
    if (bus.rx_done && bus.frame_err) both_cnt++;
    if ((bus.rx_done && prev_done) || (bus.frame_err && prev_ferr)) wide_cnt++;
    prev_done = bus.rx_done;
    prev_ferr = bus.frame_err;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int bit_clks();
    return tick_high ? OS : TICK_DIV * OS;
  endfunction

  task automatic send_bit(input logic b);
    bus.rx = b;
    repeat (bit_clks()) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic idle_bits(input int n);
    bus.rx = 1'b1;
    repeat (n * bit_clks()) @(negedge clk);
  endtask

  int d0, f0;

  initial begin
    vecs[0] = '{8'h55, 1'b1, 1, 0, 8'h55};
    vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b0, 0, 1, 8'hFF};
    vecs[4] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[5] = '{8'h80, 1'b1, 1, 0, 8'h80};

    rst = 1'b1;
    bus.rx = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_rx_data", bus.rx_data, 0);
    check("reset_rx_done", bus.rx_done, 0);
    check("reset_frame_err", bus.frame_err, 0);
    check("reset_rx_busy", bus.rx_busy, 0);
    rst = 1'b0;
    idle_bits(1);

    for (int v = 0; v < 6; v++) begin
      d0 = done_cnt; f0 = ferr_cnt;
      send_frame(vecs[v].data, vecs[v].stop);
      idle_bits(2);
      check($sformatf("vec%0d_done", v), done_cnt - d0, vecs[v].exp_done);
      check($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
      check($sformatf("vec%0d_data", v), bus.rx_data, vecs[v].exp_data);
      check($sformatf("vec%0d_busy", v), bus.rx_busy, 0);
      if (vecs[v].exp_done == 1 && done_log.size() > 0)
        check($sformatf("vec%0d_data_at_done", v), done_log[done_log.size()-1], vecs[v].exp_data);
    end

    // Start glitch: two ticks low, then idle.
    d0 = done_cnt; f0 = ferr_cnt;
    bus.rx = 1'b0;
    repeat (2 * TICK_DIV) @(negedge clk);
    idle_bits(2);
    check("glitch_done", done_cnt - d0, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);
    check("glitch_data", bus.rx_data, 8'h80);
    check("glitch_busy", bus.rx_busy, 0);

    // Back-to-back frames with no idle gap.
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    idle_bits(2);
    check("b2b_done", done_cnt - d0, 2);
    check("b2b_ferr", ferr_cnt - f0, 0);
    if (done_log.size() >= 2) begin
      check("b2b_first", done_log[done_log.size()-2], 8'hA3);
      check("b2b_second", done_log[done_log.size()-1], 8'h0F);
    end else begin
      check("b2b_log_size", done_log.size(), 2);
    end
    check("b2b_data", bus.rx_data, 8'h0F);

    // Framing error followed by a long break, then a good frame.
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    bus.rx = 1'b0;
    repeat (20 * bit_clks()) @(negedge clk);
    check("break_ferr", ferr_cnt - f0, 1);
    check("break_done", done_cnt - d0, 0);
    check("break_data", bus.rx_data, 8'h0F);
    check("break_busy", bus.rx_busy, 1);
    idle_bits(1);
    check("break_exit_busy", bus.rx_busy, 0);
    d0 = done_cnt;
    send_frame(8'h81, 1'b1);
    idle_bits(2);
    check("after_break_done", done_cnt - d0, 1);
    check("after_break_data", bus.rx_data, 8'h81);
    check("after_break_ferr_total", ferr_cnt - f0, 1);

    // Reset during bit 4 of 0xFF.
    d0 = done_cnt; f0 = ferr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus.rx = 1'b1;
    repeat (bit_clks() / 2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_data", bus.rx_data, 0);
    check("midrst_busy", bus.rx_busy, 0);
    check("midrst_done", bus.rx_done, 0);
    check("midrst_ferr", bus.frame_err, 0);
    rst = 1'b0;
    idle_bits(10);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_no_ferr", ferr_cnt - f0, 0);
    check("midrst_idle_busy", bus.rx_busy, 0);
    send_frame(8'h12, 1'b1);
    idle_bits(2);
    check("midrst_next_done", done_cnt - d0, 1);
    check("midrst_next_data", bus.rx_data, 8'h12);

    // One tick per clock.
    tick_high = 1'b1;
    idle_bits(2);
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h96, 1'b1);
    idle_bits(3);
    check("tickhigh_done", done_cnt - d0, 1);
    check("tickhigh_ferr", ferr_cnt - f0, 0);
    check("tickhigh_data", bus.rx_data, 8'h96);
    check("tickhigh_busy", bus.rx_busy, 0);

    check("pulses_overlap", both_cnt, 0);
    check("pulses_wide", wide_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
